// File: rtl/capture_buffer_reader.sv
// capture_buffer_reader: reads a frozen circular capture buffer out in time
// order, starting PRETRIG words before the trigger address, and streams the
// words over a valid/ready interface. After the last word it raises
// capture_ready and holds it until capture_valid is withdrawn.
module capture_buffer_reader #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 16,
  parameter int PRETRIG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_valid,
  output logic              capture_ready,
  input  logic [DEPTH:0]    trig_addr,
  output logic              rd_en,
  output logic [DEPTH:0]    rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int AW = DEPTH + 1;
  localparam int CW = DEPTH + 2;
  // Count value of the final word of a capture (N-1).
  localparam logic [CW-1:0] LAST_CNT = CW'((2 ** AW) - 1);
  localparam logic [AW-1:0] PRE_OFF  = AW'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] addr_r,  addr_s;
  logic [CW-1:0] cnt_r,   cnt_s;

  // Next-state, next read address and next word count.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (capture_valid) begin
          // Natural wrap of the subtraction gives the circular start address.
          addr_s  = trig_addr - PRE_OFF;
          cnt_s   = {CW{1'b0}};
          state_s = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        state_s = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (cnt_r == LAST_CNT) begin
            state_s = S_ACK;
          end else begin
            addr_s  = addr_r + AW'(1);
            cnt_s   = cnt_r + CW'(1);
            state_s = S_FETCH;
          end
        end else begin
          state_s = S_PRESENT;
        end
      end
      S_ACK: begin
        if (!capture_valid) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_ACK;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, address and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      addr_r  <= {AW{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered outputs, decoded from the state being entered so that each
  // output is aligned with its state without any combinational output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en         <= 1'b0;
      rd_addr       <= {AW{1'b0}};
      out_data      <= {DATA_W{1'b0}};
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      capture_ready <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rd_en         <= (state_s == S_FETCH);
      out_valid     <= (state_s == S_PRESENT);
      out_last      <= (state_s == S_PRESENT) && (cnt_s == LAST_CNT);
      capture_ready <= (state_s == S_ACK);
      busy          <= (state_s != S_IDLE);
      if (state_s == S_FETCH) begin
        rd_addr <= addr_s;
      end else begin
        rd_addr <= rd_addr;
      end
      // Memory returns data one cycle after the strobe, i.e. during WAIT.
      if (state_r == S_WAIT) begin
        out_data <= rd_data;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_capture_buffer_reader.sv
// Bench for capture_buffer_reader: two instances (PRETRIG 0 and 4) share the
// same stimulus; each has its own buffer memory model. A reference model
// derives the expected address/data sequence from trig_addr and PRETRIG.
module tb_capture_buffer_reader;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_valid;
  logic [4:0]  trig_addr;
  logic        out_ready;

  logic        capture_ready [2];
  logic        rd_en         [2];
  logic [4:0]  rd_addr       [2];
  logic [15:0] rd_data       [2];
  logic [15:0] out_data      [2];
  logic        out_valid     [2];
  logic        out_last      [2];
  logic        busy          [2];

  logic [15:0] mem [N];

  int n_checks = 0;
  int n_errs   = 0;

  // monitor / reference model state
  int          cyc = 0;
  int          acc_cnt      [2];
  int          fetch_cnt    [2];
  int          start_cyc    [2];
  int          last_acc_cyc [2];
  int          base         [2];
  bit          prev_valid   [2];
  logic [15:0] first_data   [2];
  logic [15:0] last_data    [2];
  logic [4:0]  first_addr   [2];

  always #5 clk = ~clk;

  capture_buffer_reader #(.DEPTH(4), .DATA_W(16), .PRETRIG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .capture_valid(capture_valid),
    .capture_ready(capture_ready[0]), .trig_addr(trig_addr),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_last(out_last[0]), .busy(busy[0])
  );

  capture_buffer_reader #(.DEPTH(4), .DATA_W(16), .PRETRIG(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .capture_valid(capture_valid),
    .capture_ready(capture_ready[1]), .trig_addr(trig_addr),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_last(out_last[1]), .busy(busy[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int pre_of(input int k);
    return (k == 0) ? 0 : 4;
  endfunction

  // i-th word of a capture comes from (trig - PRETRIG + i) mod N
  function automatic int exp_addr(input int k, input int i);
    return (base[k] + i) % N;
  endfunction

  // Buffer memory models: data valid one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rd_en[k]) rd_data[k] <= mem[rd_addr[k]];
      else          rd_data[k] <= 16'($urandom);
    end
  end

  // Monitor: checks every fetch and every presented word against the model.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check_eq("reset_outputs",
                 {25'd0, rd_en[k], out_valid[k], out_last[k], capture_ready[k],
                  busy[k], |rd_addr[k], |out_data[k]}, 32'd0);
        prev_valid[k] = 1'b0;
        acc_cnt[k]    = 0;
        fetch_cnt[k]  = 0;
      end else begin
        if (!busy[k] && capture_valid && !capture_ready[k]) begin
          acc_cnt[k]   = 0;
          fetch_cnt[k] = 0;
          start_cyc[k] = cyc;
          base[k]      = (int'(trig_addr) - pre_of(k) + N) % N;
        end
        if (rd_en[k]) begin
          check_eq("fetch_addr", 32'(rd_addr[k]), 32'(exp_addr(k, fetch_cnt[k])));
          check_eq("fetch_order", 32'(fetch_cnt[k]), 32'(acc_cnt[k]));
          check_eq("rd_en_with_valid", 32'(out_valid[k]), 32'd0);
          if (fetch_cnt[k] == 0) first_addr[k] = rd_addr[k];
          fetch_cnt[k]++;
        end
        if (out_valid[k]) begin
          if (!prev_valid[k]) begin
            if (acc_cnt[k] == 0)
              check_eq("first_latency", 32'(cyc - start_cyc[k]), 32'd3);
            else
              check_eq("word_period", 32'(cyc - last_acc_cyc[k]), 32'd3);
          end
          check_eq("out_data", 32'(out_data[k]), 32'(mem[exp_addr(k, acc_cnt[k])]));
          check_eq("out_last", 32'(out_last[k]), 32'(acc_cnt[k] == N - 1));
          if (out_ready) begin
            if (acc_cnt[k] == 0) first_data[k] = out_data[k];
            last_data[k]    = out_data[k];
            acc_cnt[k]++;
            last_acc_cyc[k] = cyc;
          end
        end else if (out_last[k]) begin
          check_eq("last_without_valid", 32'(out_last[k]), 32'd0);
        end
        if (capture_ready[k]) check_eq("words_delivered", 32'(acc_cnt[k]), 32'(N));
        prev_valid[k] = out_valid[k];
      end
    end
  end

  // mode: 0 = always ready, 1 = random ready, 2 = stall word 10, 3 = reset at word 5
  task automatic run_capture(input logic [4:0] t, input int mode, input bit hold);
    bit          done = 1'b0;
    bit          stalled = 1'b0;
    int          stall_left = 0;
    logic [15:0] stall_data = 16'd0;
    trig_addr     = t;
    capture_valid = 1'b1;
    out_ready     = 1'b1;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (capture_ready[0]) begin
        done = 1'b1;
      end else begin
        if (busy[0]) begin
          trig_addr     = 5'($urandom);
          capture_valid = (acc_cnt[0] >= N - 1) ? hold : 1'($urandom);
        end
        if (mode == 3 && acc_cnt[0] == 4 && out_valid[0]) begin
          #1 rst_n = 1'b0;
          #1;
          for (int k = 0; k < 2; k++)
            check_eq("midreset_outputs",
                     {28'd0, out_valid[k], rd_en[k], busy[k], capture_ready[k]}, 32'd0);
          capture_valid = 1'b0;
          @(posedge clk); #1 rst_n = 1'b1;
          return;
        end
        if (mode == 2 && !stalled && acc_cnt[0] == 9 && out_valid[0]) begin
          stalled    = 1'b1;
          stall_left = 5;
          stall_data = out_data[0];
        end
        if (stall_left > 0) begin
          check_eq("stall_valid", 32'(out_valid[0]), 32'd1);
          check_eq("stall_data", 32'(out_data[0]), 32'(stall_data));
          check_eq("stall_no_rd_en", 32'(rd_en[0]), 32'd0);
          out_ready = 1'b0;
          stall_left--;
        end else if (mode == 1) begin
          out_ready = 1'($urandom);
        end else begin
          out_ready = 1'b1;
        end
      end
    end
    if (!done) begin
      check_eq("timeout", 32'd1, 32'd0);
      return;
    end
    if (mode == 2) check_eq("stall_happened", 32'(stalled), 32'd1);
    if (hold) begin
      for (int i = 0; i < 6; i++) begin
        for (int k = 0; k < 2; k++) begin
          check_eq("hold_ready", 32'(capture_ready[k]), 32'd1);
          check_eq("hold_no_rd_en", 32'(rd_en[k]), 32'd0);
          check_eq("hold_busy", 32'(busy[k]), 32'd1);
        end
        @(posedge clk); #1;
      end
      capture_valid = 1'b0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("ready_falls", 32'(capture_ready[k]), 32'd0);
      check_eq("busy_idle", 32'(busy[k]), 32'd0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    capture_valid = 1'b1;
    trig_addr     = 5'd7;
    out_ready     = 1'b0;
    for (int a = 0; a < N; a++) mem[a] = {8'hA5, 3'b000, 5'(a)};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic readout straight out of reset
    run_capture(5'd7, 0, 1'b0);
    check_eq("basic_first_data", 32'(first_data[0]), 32'hA507);
    check_eq("basic_last_data", 32'(last_data[0]), 32'hA506);
    check_eq("basic_first_addr", 32'(first_addr[0]), 32'd7);
    check_eq("pre4_first_addr", 32'(first_addr[1]), 32'd3);
    repeat (2) @(posedge clk); #1;

    // pre-trigger wrap with random backpressure
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    run_capture(5'd2, 1, 1'b0);
    check_eq("wrap_first_addr", 32'(first_addr[1]), 32'd30);
    check_eq("wrap_transfers", 32'(acc_cnt[1]), 32'(N));
    check_eq("wrap_last_data", 32'(last_data[1]), 32'(mem[29]));

    // backpressure on word 10, then capture_valid held into ACK
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    run_capture(5'($urandom), 2, 1'b1);

    // reset during word 5, then a fresh capture from address 0
    run_capture(5'd17, 3, 1'b0);
    repeat (2) @(posedge clk); #1;
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
    run_capture(5'd0, 0, 1'b0);
    check_eq("after_reset_first_addr", 32'(first_addr[0]), 32'd0);
    check_eq("after_reset_count", 32'(acc_cnt[0]), 32'(N));

    // a few random captures
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
      run_capture(5'($urandom), 1, 1'($urandom));
      repeat (1 + $urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/capture_buffer_reader.md
Name: capture_buffer_reader

Overview:
Read-side counterpart to adc_driver. Once adc_driver flags a completed capture (valid), this block reads the circular capture buffer out in time order, starting PRETRIG samples before the trigger address and wrapping at the buffer end. It streams each word to the SPI module over a valid/ready handshake. When the whole buffer has been delivered, it returns ready to adc_driver so the driver can re-arm.

Parameters:
DEPTH, 4, buffer address width is DEPTH+1; buffer holds N = 2^(DEPTH+1) words (32 at default)
DATA_W, 16, sample word width
PRETRIG, 0, words read before trig_addr; 0..N-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
capture_valid  in  1  from adc_driver valid; capture complete, buffer frozen
capture_ready  out  1  to adc_driver ready; readout finished, buffer released
trig_addr  in  DEPTH+1  trigger address from adc_driver; sampled only in IDLE
rd_en  out  1  buffer memory read strobe
rd_addr  out  DEPTH+1  buffer memory read address
rd_data  in  DATA_W  buffer memory read data; valid exactly 1 cycle after the rd_en edge
out_data  out  DATA_W  sample word to SPI module
out_valid  out  1  out_data valid
out_ready  in  1  SPI module accepts out_data
out_last  out  1  high with out_valid on the final (Nth) word
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, and all outputs 0: capture_ready, rd_en, rd_addr, out_data, out_valid, out_last, busy. Internal address and count are cleared.
- Reset asserted mid-readout: abandon the transfer immediately and drop out_valid. After release, wait in IDLE for capture_valid.
- FSM states: IDLE, FETCH, WAIT, PRESENT, ACK.
- IDLE, on a rising edge with capture_valid=1:
  - addr <= trig_addr - PRETRIG, computed modulo 2^(DEPTH+1) (natural wrap of the DEPTH+1-bit subtraction).
  - cnt <= 0; go to FETCH.
- FETCH (1 cycle): rd_en=1, rd_addr=addr. Go to WAIT.
- WAIT (1 cycle): rd_en=0. At the edge, out_data <= rd_data; go to PRESENT.
- PRESENT: out_valid=1; out_last = (cnt == N-1).
  - out_data is held stable while out_ready=0.
  - On an edge with out_ready=1 and cnt < N-1: addr <= addr+1 (wraps N-1 -> 0), cnt <= cnt+1, go to FETCH.
  - On an edge with out_ready=1 and cnt == N-1: go to ACK.
- ACK: capture_ready=1, out_valid=0. On an edge with capture_valid=0, go to IDLE (capture_ready falls). This completes a four-phase handshake.
- Latency:
  - First out_valid is high 2 cycles after the IDLE edge that sampled capture_valid.
  - Each further word is presented 3 cycles after the previous acceptance.
  - Minimum word period is 3 cycles.
- cnt is DEPTH+2 bits wide. Exactly N words are delivered per capture, with no duplicates or skips.
- Input changes during readout are ignored: capture_valid and trig_addr are not observed outside IDLE and ACK.
- capture_valid still high in ACK: stay in ACK with capture_ready=1. No second readout starts.
- capture_valid already low on entry to ACK: capture_ready is high for exactly 1 cycle.
- out_ready high before out_valid has no effect. There is no combinational path from out_ready to out_valid.
- rd_en is never high outside FETCH; rd_addr holds its last value otherwise.

Test Plan:
- Reset
  - Stimulus: rst_n=0 with capture_valid=1.
  - Required: all outputs 0, no rd_en. After release, readout starts on the first edge with capture_valid=1.
- Basic readout
  - Stimulus: DEPTH=4, PRETRIG=0, trig_addr=7, memory model data={8'hA5, 3'b0, addr}, out_ready=1.
  - Required: 32 words with rd_addr 7..31, then 0..6. out_data 16'hA507 first and 16'hA506 last. out_last only on word 32. First out_valid 2 cycles after capture_valid was sampled; word period 3 cycles.
- Pre-trigger wrap
  - Stimulus: PRETRIG=4, trig_addr=2.
  - Required: first rd_addr=30, then 31, 0, 1, ...; last word from addr 29. Exactly 32 out_valid&out_ready transfers.
- Backpressure
  - Stimulus: hold out_ready=0 for 5 cycles during word 10.
  - Required: out_valid stays 1 and out_data is unchanged; no rd_en pulses. Word 11 is fetched only after acceptance.
- Handshake
  - Stimulus: keep capture_valid=1 for 6 cycles after the last word is accepted.
  - Required: capture_ready stays 1 for those 6 cycles and falls on the edge after capture_valid drops. busy returns to 0. No new rd_en.
- Reset mid-readout
  - Stimulus: pulse rst_n low during word 5, then start a new capture with trig_addr=0.
  - Required: out_valid drops immediately. The new readout starts at addr 0 with cnt reset, and out_last appears on word 32.
